ram_fifo_ctrl: RTL and testbench

Controller that turns the 16x16 single-port `RAM` into a first-in/first-out buffer with valid/ready handshakes on both sides. It sits directly upstream of `RAM`. It drives the RAM's `A`, `WE`, `OE` and `D` pins, samples `Q`, and presents the head word in a one-entry output register. Producer and consumer blocks attach to its stream ports; only this block touches the RAM.

---
 rtl/ram_fifo_pkg.sv | 13 +
 rtl/ram_fifo_ctrl.sv | 98 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared constants and FSM state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous RAM with valid/ready streams
// on both sides and a one-entry registered output stage.
module ram_fifo_ctrl #(
  parameter int DW = ram_fifo_pkg::DW,
  parameter int AW = ram_fifo_pkg::AW
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic [AW-1:0] RAM_A,
  output logic          RAM_WE,
  output logic          RAM_OE,
  output logic [DW-1:0] RAM_D,
  input  logic [DW-1:0] RAM_Q
);
  import ram_fifo_pkg::*;

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic slot_free, rd_issue, in_ready_c, wr_fire, capture;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    // Strobes are gated by RST so the RAM sees no access while held in reset.
    rd_issue   = !RST && (state_q == IDLE) && (count_q != '0) && slot_free;
    in_ready_c = !RST && (count_q != FULL_CNT) && !rd_issue;
    wr_fire    = in_valid && in_ready_c;
    capture    = !RST && (state_q == RD_WAIT);

    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_fire) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end else if (rd_issue) begin
      count_d = count_q - 1'b1;
    end

    if (rd_issue) begin
      rptr_d  = rptr_q + 1'b1;
      state_d = RD_WAIT;
    end

    if (capture) begin
      state_d     = IDLE;
      out_valid_d = 1'b1;
      out_data_d  = RAM_Q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign RAM_A     = rd_issue ? rptr_q : wptr_q;
  assign RAM_WE    = wr_fire;
  assign RAM_OE    = capture;
  assign RAM_D     = in_data;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 16x16 synchronous RAM and a
// queue-based scoreboard checking the output stream.
module tb_ram_fifo_ctrl;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [4:0]  count;
  logic [3:0]  RAM_A;
  logic        RAM_WE;
  logic        RAM_OE;
  logic [15:0] RAM_D;
  wire  [15:0] RAM_Q;

  ram_fifo_ctrl #(.DW(16), .AW(4)) dut (
    .CK(CK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .RAM_A(RAM_A), .RAM_WE(RAM_WE), .RAM_OE(RAM_OE), .RAM_D(RAM_D), .RAM_Q(RAM_Q)
  );

  always #5 CK = ~CK;

  // RAM model: address registered on the edge, read word driven only while OE.
  logic [15:0] mem [16];
  logic [15:0] ram_qr = '0;
  always @(posedge CK) begin
    if (RAM_WE) mem[RAM_A] <= RAM_D;
    else        ram_qr     <= mem[RAM_A];
  end
  assign RAM_Q = RAM_OE ? ram_qr : 16'hzzzz;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_acc = 0;
  int unsigned n_pop = 0;
  int unsigned cyc_n = 0;
  logic [15:0] exp_q [$];
  int unsigned pop_cyc [$];

  always @(posedge CK) cyc_n <= cyc_n + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Output monitor: every consumer handshake pops the next expected word.
  always @(negedge CK) begin
    if (!RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_underflow: got %0h expected none", out_data);
      end else begin
        chk("pop_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
      n_pop++;
      pop_cyc.push_back(cyc_n);
    end
  end

  // One clock: record accepted pushes into the scoreboard, return #1 after the edge.
  task automatic cyc();
    @(negedge CK);
    if (!RST && in_valid && in_ready) begin
      exp_q.push_back(in_data);
      n_acc++;
    end
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    cyc();
    cyc();
    RST = 1'b0;
    n_acc = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned bound;
    int unsigned pops0;

    // Reset: strobes held low even with a push offered.
    in_valid = 1'b1;
    RST = 1'b1;
    #2;
    chk("rst_in_ready", {31'h0, in_ready}, 0);
    chk("rst_we", {31'h0, RAM_WE}, 0);
    cyc();
    in_valid = 1'b0;
    do_reset();
    chk("rel_out_valid", {31'h0, out_valid}, 0);
    chk("rel_count", {27'h0, count}, 0);
    chk("rel_in_ready", {31'h0, in_ready}, 1);
    chk("rel_we", {31'h0, RAM_WE}, 0);
    chk("rel_oe", {31'h0, RAM_OE}, 0);

    // Arbitration: hold w0 in the output, three words in RAM (rptr=1, wptr=4).
    in_valid = 1'b1;
    out_ready = 1'b0;
    bound = 0;
    while (n_acc < 4 && bound < 20) begin
      in_data = 16'h5000 + 16'(n_acc);
      cyc();
      bound++;
    end
    chk("arb_setup_acc", n_acc, 4);
    in_data = 16'h5004;
    out_ready = 1'b1;
    #1;
    chk("arb_count", {27'h0, count}, 3);
    chk("arb_in_ready", {31'h0, in_ready}, 0);
    chk("arb_we", {31'h0, RAM_WE}, 0);
    chk("arb_addr_rptr", {28'h0, RAM_A}, 1);
    cyc();
    out_ready = 1'b0;
    #1;
    chk("arb_rdw_oe", {31'h0, RAM_OE}, 1);
    chk("arb_rdw_in_ready", {31'h0, in_ready}, 1);
    chk("arb_rdw_we", {31'h0, RAM_WE}, 1);
    chk("arb_rdw_addr_wptr", {28'h0, RAM_A}, 4);
    cyc();
    in_valid = 1'b0;
    do_reset();

    // Fill: 16 in RAM plus the output register.
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_data = 16'h1000 + 16'(n_acc);
      cyc();
    end
    #1;
    chk("fill_accepted", n_acc, 17);
    chk("fill_out_data", {16'h0, out_data}, 32'h1000);
    chk("fill_out_valid", {31'h0, out_valid}, 1);
    chk("fill_count", {27'h0, count}, 16);
    chk("fill_in_ready", {31'h0, in_ready}, 0);
    chk("fill_we", {31'h0, RAM_WE}, 0);

    // Drain: pops arrive every second cycle.
    in_valid = 1'b0;
    pops0 = n_pop;
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    chk("drain_pops", n_pop - pops0, 17);
    chk("drain_count", {27'h0, count}, 0);
    chk("drain_out_valid", {31'h0, out_valid}, 0);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("drain_gap", pop_cyc[i] - pop_cyc[i-1], 2);
    chk("drain_sb_empty", exp_q.size(), 0);

    // Wrap: 40 words with random handshakes on both sides.
    do_reset();
    pops0 = n_pop;
    bound = 0;
    while ((n_acc < 40 || n_pop - pops0 < 40) && bound < 3000) begin
      in_valid  = (n_acc < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 16'hA000 + 16'(n_acc);
      out_ready = 1'($urandom_range(0, 1));
      cyc();
      bound++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wrap_accepted", n_acc, 40);
    chk("wrap_received", n_pop - pops0, 40);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Reset during RD_WAIT drops the in-flight word.
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h7777;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mid_rdwait_oe", {31'h0, RAM_OE}, 1);
    RST = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_oe", {31'h0, RAM_OE}, 0);
    cyc();
    chk("mid_out_valid", {31'h0, out_valid}, 0);
    chk("mid_count", {27'h0, count}, 0);
    chk("mid_oe", {31'h0, RAM_OE}, 0);
    RST = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h8888;
    out_ready = 1'b1;
    pops0 = n_pop;
    cyc();
    in_valid = 1'b0;
    bound = 0;
    while (n_pop == pops0 && bound < 20) begin
      cyc();
      bound++;
    end
    chk("mid_first_out", n_pop - pops0, 1);
    chk("mid_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
